// File: rtl/im_boot_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
// Optional feature macro: IM_BOOT_CHECKSUM_EN (adds the trailing XOR checksum byte).
package im_boot_pkg;

    localparam logic [31:0] IM_BOOT_ADDR_BASE = 32'h0000_3000;
    localparam int unsigned IM_BOOT_WORDS     = 4096;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } bootState_e;

endpackage

// File: rtl/byte_packer.sv
// Packs a big-endian byte stream into 32-bit words: first byte lands in [31:24].
// The completed word and its done flag are presented combinationally on the
// fourth beat so the caller can register the IM write in the following cycle.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        beat,
    input  logic [7:0]  byteIn,
    output logic [31:0] word_c,
    output logic        wordDone_c
);

    logic [1:0]  lane;
    logic [23:0] shiftReg;

    // Lane counter and shift register; a partial word simply waits for more beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane     <= 2'd0;
            shiftReg <= 24'd0;
        end else if (clear) begin
            lane     <= 2'd0;
            shiftReg <= 24'd0;
        end else if (beat) begin
            lane     <= lane + 2'd1;
            shiftReg <= {shiftReg[15:0], byteIn};
        end
    end

    assign word_c     = {shiftReg, byteIn};
    assign wordDone_c = beat && (lane == 2'd3);

endmodule

// File: rtl/im_boot_loader.sv
// Byte-stream boot loader: holds the CPU in reset, writes a counted image into
// IM starting at ADDR_BASE, then asserts cpu_run.
// Optional feature macro: IM_BOOT_CHECKSUM_EN (one XOR trailer byte after the payload).
module im_boot_loader
    import im_boot_pkg::*;
#(
    parameter int unsigned WORDS     = IM_BOOT_WORDS,
    parameter logic [31:0] ADDR_BASE = IM_BOOT_ADDR_BASE,
    parameter int unsigned CW        = $clog2(WORDS) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          im_we,
    output logic [31:0]   im_addr,
    output logic [31:0]   im_wdata,
    output logic          cpu_run,
    output logic          load_err,
    output logic [CW-1:0] words_loaded
);

    bootState_e    state;
    logic [7:0]    hdrHi;
    logic [CW-1:0] wordCount;
    logic          beat;
    logic          restart;
    logic [15:0]   hdrCount;
    logic [31:0]   packedWord_c;
    logic          wordDone_c;
`ifdef IM_BOOT_CHECKSUM_EN
    logic [7:0]    csumAcc;
`endif

    assign beat     = in_valid && in_ready;
    assign restart  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign hdrCount = {hdrHi, in_data};

    byte_packer uPacker (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .beat       (beat && (state == DATA)),
        .byteIn     (in_data),
        .word_c     (packedWord_c),
        .wordDone_c (wordDone_c)
    );

    // Load FSM with registered outputs. After the last word's fourth beat in_ready
    // drops while im_we fires; the following cycle moves on, so cpu_run never
    // rises while the final word is still being written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            hdrHi        <= 8'd0;
            wordCount    <= '0;
            in_ready     <= 1'b0;
            im_we        <= 1'b0;
            im_addr      <= 32'd0;
            im_wdata     <= 32'd0;
            cpu_run      <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
`ifdef IM_BOOT_CHECKSUM_EN
            csumAcc      <= 8'd0;
`endif
        end else begin
            im_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= HDR0;
                        in_ready     <= 1'b1;
                        load_err     <= 1'b0;
                        cpu_run      <= 1'b0;
                        words_loaded <= '0;
`ifdef IM_BOOT_CHECKSUM_EN
                        csumAcc      <= 8'd0;
`endif
                    end
                end
                HDR0: begin
                    if (beat) begin
                        hdrHi <= in_data;
                        state <= HDR1;
                    end
                end
                HDR1: begin
                    if (beat) begin
                        if ((hdrCount == 16'd0) || (32'(hdrCount) > WORDS)) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            wordCount <= CW'(hdrCount);
                            state     <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (!in_ready) begin
`ifdef IM_BOOT_CHECKSUM_EN
                        state    <= CSUM;
                        in_ready <= 1'b1;
`else
                        state    <= DONE;
                        cpu_run  <= 1'b1;
`endif
                    end else if (beat) begin
`ifdef IM_BOOT_CHECKSUM_EN
                        csumAcc <= csumAcc ^ in_data;
`endif
                        if (wordDone_c) begin
                            im_we        <= 1'b1;
                            im_addr      <= ADDR_BASE + 32'({words_loaded, 2'b00});
                            im_wdata     <= packedWord_c;
                            words_loaded <= words_loaded + CW'(1);
                            if ((words_loaded + CW'(1)) == wordCount) begin
                                in_ready <= 1'b0;
                            end
                        end
                    end
                end
`ifdef IM_BOOT_CHECKSUM_EN
                CSUM: begin
                    if (beat) begin
                        in_ready <= 1'b0;
                        if (csumAcc == in_data) begin
                            state   <= DONE;
                            cpu_run <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed self-checking bench for im_boot_loader (default or IM_BOOT_CHECKSUM_EN build).
module tb_im_boot_loader;

    localparam int unsigned CW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          im_we;
    logic [31:0]   im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_run;
    logic          load_err;
    logic [CW-1:0] words_loaded;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] weAddrQ[$];
    logic [31:0] weDataQ[$];
    logic [7:0]  payloadQ[$];
    int          gapQ[$];
    logic        weLast = 1'b0;

    im_boot_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .cpu_run      (cpu_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Capture every IM write; a write strobe must never last two cycles.
    always @(negedge clk) begin
        if (im_we) begin
            weAddrQ.push_back(im_addr);
            weDataQ.push_back(im_wdata);
            vectors++;
            if (weLast) begin
                miscompares++;
                $display("FAIL we_width: im_we high 2+ consecutive cycles at addr %h, required 1", im_addr);
            end
        end
        weLast = im_we;
    end

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles and wait (bounded) for the handshake.
    task automatic sendByte(input logic [7:0] b, input int gap);
        int guard;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (!in_ready) begin
            miscompares++;
            $display("FAIL byte_accept: in_ready=0 for byte %h after %0d cycles, required 1", b, guard);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

`ifdef IM_BOOT_CHECKSUM_EN
    function automatic logic [7:0] payloadXor();
        logic [7:0] x = 8'h00;
        foreach (payloadQ[i]) x = x ^ payloadQ[i];
        return x;
    endfunction
`endif

    // Full load of payloadQ: header, payload (optional gaps, optional stray start), trailer.
    task automatic loadImage(input logic [15:0] n, input bit useGaps, input int strayStartAt,
                             input bit badTrailer);
        weAddrQ.delete();
        weDataQ.delete();
        pulseStart();
        sendByte(n[15:8], 0);
        sendByte(n[7:0], 0);
        foreach (payloadQ[i]) begin
            if (i == strayStartAt) pulseStart();
            sendByte(payloadQ[i], useGaps ? gapQ[i % gapQ.size()] : 0);
        end
`ifdef IM_BOOT_CHECKSUM_EN
        sendByte(badTrailer ? 8'h00 : payloadXor(), 0);
`else
        if (badTrailer) $display("note: trailer request ignored without checksum build");
`endif
    endtask

    // Bounded wait for the load to finish either way.
    task automatic waitEnd();
        int guard = 0;
        while (!cpu_run && !load_err && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (!cpu_run && !load_err) begin
            miscompares++;
            $display("FAIL end_timeout: neither cpu_run nor load_err after %0d cycles, required one", guard);
        end
    endtask

    task automatic setTwoWordPayload();
        payloadQ = '{8'h3C, 8'h01, 8'h87, 8'h65, 8'h34, 8'h21, 8'h43, 8'h21};
    endtask

    task automatic checkTwoWordWrites(input string tag);
        vectors++;
        if (weAddrQ.size() !== 2) begin
            miscompares++;
            $display("FAIL %s_count: %0d writes, required 2", tag, weAddrQ.size());
        end else begin
            vectors += 2;
            if (weAddrQ[0] !== 32'h0000_3000 || weDataQ[0] !== 32'h3C01_8765) begin
                miscompares++;
                $display("FAIL %s_w0: %h@%h, required 3c018765@00003000", tag, weDataQ[0], weAddrQ[0]);
            end
            if (weAddrQ[1] !== 32'h0000_3004 || weDataQ[1] !== 32'h3421_4321) begin
                miscompares++;
                $display("FAIL %s_w1: %h@%h, required 34214321@00003004", tag, weDataQ[1], weAddrQ[1]);
            end
        end
        vectors += 2;
        if (cpu_run !== 1'b1 || load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done: cpu_run=%b load_err=%b, required 1/0", tag, cpu_run, load_err);
        end
        if (words_loaded !== 13'd2 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_wl: words_loaded=%0d in_ready=%b, required 2/0", tag, words_loaded, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        vectors++;
        if ({in_ready, im_we, cpu_run, load_err} !== 4'b0 || im_addr !== 32'd0 ||
            im_wdata !== 32'd0 || words_loaded !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%b we=%b run=%b err=%b addr=%h data=%h wl=%0d, required all 0",
                     in_ready, im_we, cpu_run, load_err, im_addr, im_wdata, words_loaded);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready: in_ready=%b in IDLE, required 0", in_ready);
        end
    endtask

    task automatic test_reset_mid_data();
        setTwoWordPayload();
        pulseStart();
        sendByte(8'h00, 0);
        sendByte(8'h02, 0);
        for (int i = 0; i < 6; i++) sendByte(payloadQ[i], 0);
        reset = 1'b0;
        #1;
        vectors++;
        if ({in_ready, im_we, cpu_run, load_err} !== 4'b0 || im_addr !== 32'd0 ||
            im_wdata !== 32'd0 || words_loaded !== 13'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: rdy=%b we=%b run=%b err=%b addr=%h wl=%0d, required all 0",
                     in_ready, im_we, cpu_run, load_err, im_addr, words_loaded);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        loadImage(16'd2, 1'b0, -1, 1'b0);
        waitEnd();
        checkTwoWordWrites("reload");
    endtask

    task automatic test_basic_load();
        setTwoWordPayload();
        loadImage(16'd2, 1'b0, -1, 1'b0);
        waitEnd();
        checkTwoWordWrites("basic");
    endtask

    task automatic test_bad_header();
        weAddrQ.delete();
        pulseStart();
        vectors++;
        if (cpu_run !== 1'b0 || words_loaded !== 13'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_clear: run=%b wl=%0d rdy=%b, required 0/0/1", cpu_run, words_loaded, in_ready);
        end
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        vectors++;
        if (load_err !== 1'b1 || in_ready !== 1'b0 || cpu_run !== 1'b0) begin
            miscompares++;
            $display("FAIL hdr_zero: err=%b rdy=%b run=%b, required 1/0/0", load_err, in_ready, cpu_run);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (weAddrQ.size() !== 0 || load_err !== 1'b1) begin
            miscompares++;
            $display("FAIL hdr_zero_hold: writes=%0d err=%b, required 0/1", weAddrQ.size(), load_err);
        end
        pulseStart();
        vectors++;
        if (load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: load_err=%b after start, required 0", load_err);
        end
        sendByte(8'h10, 0);
        sendByte(8'h01, 0);
        vectors++;
        if (load_err !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hdr_4097: err=%b rdy=%b, required 1/0", load_err, in_ready);
        end
    endtask

    task automatic test_gaps();
        setTwoWordPayload();
        gapQ = '{0, 2, 0, 1, 3, 0, 4, 1};
        loadImage(16'd2, 1'b1, 5, 1'b0);
        waitEnd();
        checkTwoWordWrites("gaps");
    endtask

    task automatic test_full_image();
        logic [15:0] idx;
        payloadQ.delete();
        for (int i = 0; i < 4096; i++) begin
            idx = 16'(i);
            payloadQ.push_back(idx[15:8]);
            payloadQ.push_back(idx[7:0]);
            payloadQ.push_back(~idx[15:8]);
            payloadQ.push_back(~idx[7:0]);
        end
        loadImage(16'd4096, 1'b0, -1, 1'b0);
        waitEnd();
        vectors++;
        if (weAddrQ.size() !== 4096) begin
            miscompares++;
            $display("FAIL full_count: %0d writes, required 4096", weAddrQ.size());
        end else begin
            vectors += 2;
            if (weAddrQ[4095] !== 32'h0000_6FFC || weDataQ[4095] !== 32'h0FFF_F000) begin
                miscompares++;
                $display("FAIL full_last: %h@%h, required 0ffff000@00006ffc", weDataQ[4095], weAddrQ[4095]);
            end
            if (weAddrQ[1234] !== 32'h0000_4348 || weDataQ[1234] !== 32'h04D2_FB2D) begin
                miscompares++;
                $display("FAIL full_mid: %h@%h, required 04d2fb2d@00004348", weDataQ[1234], weAddrQ[1234]);
            end
        end
        vectors++;
        if (words_loaded !== 13'd4096 || cpu_run !== 1'b1 || load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL full_done: wl=%0d run=%b err=%b, required 4096/1/0", words_loaded, cpu_run, load_err);
        end
    endtask

`ifdef IM_BOOT_CHECKSUM_EN
    // Payload XOR of the two-word image is 0xA8; 0x00 must be rejected.
    task automatic test_checksum();
        setTwoWordPayload();
        loadImage(16'd2, 1'b0, -1, 1'b1);
        waitEnd();
        vectors++;
        if (load_err !== 1'b1 || cpu_run !== 1'b0 || weAddrQ.size() !== 2) begin
            miscompares++;
            $display("FAIL csum_bad: err=%b run=%b writes=%0d, required 1/0/2", load_err, cpu_run, weAddrQ.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_bad_header();
        test_reset_mid_data();
        test_gaps();
        test_full_image();
`ifdef IM_BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
